rr_fair_arbiter: RTL

Round-robin arbiter with bounded hold time and optional age-based priority escalation. It owns a shared resource and drives a registered one-hot grant to up to NUM_REQUESTERS clients. It produces the req/grant traffic that the team's fairness property checkers observe. Worst-case waiting is bounded by construction.

---
 rtl/arb_pkg.sv | 23 ++
 rtl/rr_fair_arbiter_rr_pick.sv | 44 ++++
 rtl/rr_fair_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin fair arbiter.
// Holds the requester mask type, the two-state FSM encoding and the index-width helper.
// Pure declarations: no logic, no latency, no flow control.
package arb_pkg;

  // Default client count used by the arbiter top.
  localparam int ARB_NUM_REQ = 4;

  // Requester mask at the default client count.
  typedef logic [ARB_NUM_REQ-1:0] req_mask_t;

  // Arbiter ownership state.
  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  // Width of a client index. Never returns less than 1, so a 2-client build still gets a real bus.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_fair_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set bit of i_mask at or above i_start, wrapping to 0.
// Latency: zero cycles (pure combinational).
// Backpressure: none; o_found is low when i_mask is empty, and then o_onehot/o_idx are zero.
//   i_mask   : candidate mask
//   i_start  : highest-priority index (must be < N)
//   o_onehot : one-hot winner
//   o_idx    : winner index
//   o_found  : any candidate present
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_mask,
  input  logic [IW-1:0] i_start,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  logic [N-1:0] w_upper;  // candidates at or above the start pointer
  logic [N-1:0] w_sel;    // the half of the ring searched lowest-first

  always_comb begin
    w_upper  = '0;
    w_sel    = '0;
    o_onehot = '0;
    o_idx    = '0;
    o_found  = |i_mask;
    for (int i = 0; i < N; i++) begin
      w_upper[i] = i_mask[i] && (IW'(i) >= i_start);
    end
    // Anything at/above the pointer beats the wrapped-around low part.
    w_sel = (|w_upper) ? w_upper : i_mask;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (w_sel[i]) begin
        o_onehot    = '0;
        o_onehot[i] = 1'b1;
        o_idx       = IW'(i);
      end
    end
  end

endmodule

// File: rtl/rr_fair_arbiter.sv
// Round-robin arbiter with bounded hold time; optional age-based escalation under ARB_AGING_EN.
// Latency: one cycle from sampled request to registered grant; handoff is back-to-back.
// Backpressure: a waiting client is served within (N-1)*HOLD_MAX+1 cycles; an owner is preempted after HOLD_MAX cycles only if someone else is waiting.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req         : per-client request level
//   grant       : registered one-hot grant (or zero); grant_valid = |grant; grant_id = owner index (0 when idle)
//   aged        : per-client wait counter at MAX_WAIT (constant 0 without ARB_AGING_EN)
module rr_fair_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQUESTERS = ARB_NUM_REQ,
  parameter int HOLD_MAX       = 4,
  parameter int MAX_WAIT       = 6
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQUESTERS-1:0]        req,
  output logic [NUM_REQUESTERS-1:0]        grant,
  output logic                             grant_valid,
  output logic [idx_w(NUM_REQUESTERS)-1:0] grant_id,
  output logic [NUM_REQUESTERS-1:0]        aged
);

  localparam int IW = idx_w(NUM_REQUESTERS);
  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);

  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_REQUESTERS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
  localparam logic [WW-1:0] WAIT_SAT  = WW'(MAX_WAIT);

  state_e                    r_state,  w_state_nxt;
  logic [NUM_REQUESTERS-1:0] r_grant,  w_grant_nxt;
  logic [IW-1:0]             r_owner,  w_owner_nxt;
  logic [IW-1:0]             r_ptr,    w_ptr_nxt;
  logic [HW-1:0]             r_hold,   w_hold_nxt;

  logic [WW-1:0]             w_wait [NUM_REQUESTERS];
  logic [NUM_REQUESTERS-1:0] w_others;
  logic [NUM_REQUESTERS-1:0] w_aged_pend;
  logic [NUM_REQUESTERS-1:0] w_pick_mask;
  logic [NUM_REQUESTERS-1:0] w_pick_onehot;
  logic [IW-1:0]             w_pick_idx;
  logic                      w_pick_found;
  logic                      w_hold_sat;
  logic                      w_handoff;
  logic [IW-1:0]             w_ptr_after;

`ifdef ARB_AGING_EN
  logic [WW-1:0] r_wait [NUM_REQUESTERS];

  // Counts cycles spent requesting without the grant; any gap or a grant restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQUESTERS; i++) r_wait[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
        if (req[i] && !r_grant[i]) begin
          if (r_wait[i] != WAIT_SAT) r_wait[i] <= r_wait[i] + WW'(1);
        end else begin
          r_wait[i] <= '0;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : g_wait
    assign w_wait[g] = r_wait[g];
  end
`else
  // No counters: wait is pinned at zero, so aged never fires (MAX_WAIT >= 1).
  for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : g_wait
    assign w_wait[g] = '0;
  end
`endif

  for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : g_aged
    assign aged[g] = (w_wait[g] == WAIT_SAT);
  end

  // Everyone asking except the current owner; in IDLE this is simply req.
  assign w_others    = req & ~r_grant;
  // Only still-requesting non-owners may escalate.
  assign w_aged_pend = aged & w_others;
  assign w_pick_mask = (|w_aged_pend) ? w_aged_pend : w_others;

  rr_pick #(
    .N  (NUM_REQUESTERS),
    .IW (IW)
  ) u_pick (
    .i_mask   (w_pick_mask),
    .i_start  (r_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_found  (w_pick_found)
  );

  assign w_hold_sat  = (r_hold == HOLD_LAST);
  assign w_handoff   = !(|(req & r_grant))
                    || (w_hold_sat && (|w_others))
                    || (|w_aged_pend);
  assign w_ptr_after = (w_pick_idx == IDX_LAST) ? '0 : w_pick_idx + IW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    case (r_state)
      IDLE: begin
        if (w_pick_found) begin
          w_state_nxt = OWNED;
          w_grant_nxt = w_pick_onehot;
          w_owner_nxt = w_pick_idx;
          w_ptr_nxt   = w_ptr_after;
          w_hold_nxt  = '0;
        end
      end
      OWNED: begin
        if (w_handoff) begin
          if (w_pick_found) begin
            w_grant_nxt = w_pick_onehot;
            w_owner_nxt = w_pick_idx;
            w_ptr_nxt   = w_ptr_after;
            w_hold_nxt  = '0;
          end else begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
            w_owner_nxt = '0;
            w_hold_nxt  = '0;
          end
        end else if (!w_hold_sat) begin
          w_hold_nxt = r_hold + HW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
        w_owner_nxt = '0;
        w_hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  assign grant       = r_grant;
  assign grant_valid = |r_grant;
  assign grant_id    = r_owner;

endmodule
